// File: rtl/awgn_pkg.sv
// Shared fixed-point format constants for the Box-Muller AWGN datapath.
package awgn_pkg;

    // f: unsigned magnitude term, UQ4.13
    localparam int unsigned F_W    = 17;
    localparam int unsigned F_FRAC = 13;

    // g: signed trig term, Q1.15
    localparam int unsigned G_W    = 16;
    localparam int unsigned G_FRAC = 15;

    // x: signed Gaussian sample, Q5.11
    localparam int unsigned X_W    = 16;
    localparam int unsigned X_FRAC = 11;

    // Right shift taking the full product (28 fractional bits) down to X_FRAC
    localparam int unsigned SHIFT = F_FRAC + G_FRAC - X_FRAC;

    // Full signed product width: f zero-extended by one bit, times g
    localparam int unsigned P_W = F_W + 1 + G_W;

endpackage : awgn_pkg

// File: rtl/awgn_smul.sv
// Combinational signed x unsigned multiplier producing the full-width product.
module awgn_smul
    import awgn_pkg::*;
(
    input  logic [F_W-1:0]        a_i,   // unsigned operand
    input  logic [G_W-1:0]        b_i,   // two's complement operand
    output logic signed [P_W-1:0] p_o    // exact signed product
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // Extend both operands to the product width so the multiply is exact and width-clean
    always_comb begin
        a_ext = {{(P_W - F_W){1'b0}}, a_i};
        b_ext = {{(P_W - G_W){b_i[G_W-1]}}, b_i};
        p_o   = a_ext * b_ext;
    end

endmodule : awgn_smul

// File: rtl/awgn_mult.sv
// Fixed-point scaling multiplier: x (Q5.11) = f (UQ4.13) * g (Q1.15), registered.
module awgn_mult
    import awgn_pkg::*;
(
    input  logic           clk,
    input  logic           rst,       // asynchronous, active low
    input  logic [F_W-1:0] mult_in1,  // f, unsigned UQ4.13
    input  logic [G_W-1:0] mult_in2,  // g, signed Q1.15
    output logic [X_W-1:0] mult_out   // x, signed Q5.11
);

    logic signed [P_W-1:0] product;
    logic [X_W-1:0]        mult_out_d;
    logic [X_W-1:0]        mult_out_q;

    // Bits dropped by the slice: fraction below the output LSB (floor) and pure sign extension
    logic                  unused_product_bits;

    awgn_smul u_smul (
        .a_i (mult_in1),
        .b_i (mult_in2),
        .p_o (product)
    );

    // Taking the slice directly equals an arithmetic right shift by SHIFT, i.e. floor rounding
    always_comb begin
        mult_out_d          = product[SHIFT+X_W-1:SHIFT];
        unused_product_bits = ^{product[P_W-1:SHIFT+X_W], product[SHIFT-1:0]};
    end

    // Output register; reset forces zero immediately regardless of clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_out_q <= '0;
        end else begin
            mult_out_q <= mult_out_d;
        end
    end

    assign mult_out = mult_out_q;

endmodule : awgn_mult

// File: tb/tb_awgn_mult.sv
// Self-checking bench for awgn_mult using a scoreboard queue of expected samples.
module tb_awgn_mult;

    logic        clk;
    logic        rst;
    logic [16:0] mult_in1;
    logic [15:0] mult_in2;
    logic [15:0] mult_out;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    awgn_mult u_dut (
        .clk      (clk),
        .rst      (rst),
        .mult_in1 (mult_in1),
        .mult_in2 (mult_in2),
        .mult_out (mult_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact product in 64 bits, then floor by arithmetic shift of 17
    function automatic logic [15:0] model(input logic [16:0] f, input logic [15:0] g);
        longint p;
        p = longint'(f) * longint'($signed(g));
        p = p >>> 17;
        return p[15:0];
    endfunction

    // Drive one operand pair on the falling edge and queue its expected sample
    task automatic drive(input string tag, input logic [16:0] f, input logic [15:0] g);
        @(negedge clk);
        mult_in1 = f;
        mult_in2 = g;
        exp_q.push_back(model(f, g));
        tag_q.push_back(tag);
    endtask

    // Monitor: each rising edge retires whatever was driven before it
    initial begin
        logic [15:0] e;
        string       t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, mult_out, e);
            end
        end
    end

    initial begin
        int wait_cycles;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        mult_in1 = '0;
        mult_in2 = '0;

        // Get a nonzero value into the register first so reset has something to clear
        drive("half", 17'h02000, 16'h4000);
        check("half_const", model(17'h02000, 16'h4000), 16'h0400);
        @(posedge clk);
        #3;
        mult_in1 = 17'h1ABCD;
        mult_in2 = 16'h5A5A;
        rst      = 1'b0;
        #1;
        check("async_reset", mult_out, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", mult_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors, including the boundary cases
        drive("half",      17'h02000, 16'h4000);
        drive("neg_one",   17'h02000, 16'h8000);
        drive("max_pos",   17'h1FFFF, 16'h7FFF);
        drive("max_neg",   17'h1FFFF, 16'h8000);
        drive("floor_lsb", 17'h00001, 16'hFFFF);
        drive("f_zero",    17'h00000, 16'h7FFF);
        drive("g_zero",    17'h1FFFF, 16'h0000);
        check("neg_one_const", model(17'h02000, 16'h8000), 16'hF800);
        check("max_pos_const", model(17'h1FFFF, 16'h7FFF), 16'h7FFE);
        check("max_neg_const", model(17'h1FFFF, 16'h8000), 16'h8000);
        check("floor_const",   model(17'h00001, 16'hFFFF), 16'hFFFF);

        // Back-to-back stream of random operands
        for (int i = 0; i < 10; i++) begin
            drive($sformatf("stream%0d", i), 17'($urandom), 16'($urandom));
        end

        // Reset pulse mid-stream, between edges
        drive("pre_pulse", 17'h0F0F0, 16'hC3A5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("pulse_reset", mult_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        mult_in1 = 17'h12345;
        mult_in2 = 16'h9876;
        exp_q.push_back(model(17'h12345, 16'h9876));
        tag_q.push_back("resume0");
        for (int i = 1; i < 4; i++) begin
            drive($sformatf("resume%0d", i), 17'($urandom), 16'($urandom));
        end

        // Let the scoreboard drain, bounded
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        check("drain", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_awgn_mult
